// File: rtl/vnu_control_unit_pkg.sv
`default_nettype none
// ============================================================================
// Module      : vnu_control_unit_pkg
// Description : Shared decoder definitions: CNU/VNU controller defaults,
//               VNU control FSM state encodings and width helpers.
// Revision    : 1.0 - initial release
// ============================================================================
package vnu_control_unit_pkg;

    // CNU controller defaults
    localparam int CNU_LAYER_NUM_DEF        = 3;
    localparam int CNU_PIPELINE_LEVEL_DEF   = 4;
    localparam int CNU_MEM_WR_LEVEL_DEF     = 1;

    // VNU controller defaults
    localparam int VNU_LAYER_NUM_DEF        = 3;
    localparam int VNU_MAX_ITER_DEF         = 8;
    localparam int VNU_MEM_RD_LEVEL_DEF     = 2;
    localparam int VNU_PIPELINE_LEVEL_DEF   = 3;
    localparam int VNU_IB_LOAD_CYCLE_DEF    = 4;

    localparam logic [2:0] VNU_ST_IDLE      = 3'd0;
    localparam logic [2:0] VNU_ST_C2V_FETCH = 3'd1;
    localparam logic [2:0] VNU_ST_VNU_PIPE  = 3'd2;
    localparam logic [2:0] VNU_ST_V2C_WB    = 3'd3;
    localparam logic [2:0] VNU_ST_LAYER_END = 3'd4;
    localparam logic [2:0] VNU_ST_IB_UPDATE = 3'd5;
    localparam logic [2:0] VNU_ST_DONE      = 3'd6;

    // Bits needed to hold 0..n-1, never less than one
    function automatic int idx_w(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

    function automatic int max3(input int a, input int b, input int c);
        int m;
        m = (a > b) ? a : b;
        return (m > c) ? m : c;
    endfunction

endpackage
`default_nettype wire

// File: rtl/vnu_stage_timer.sv
`default_nettype none
// ============================================================================
// Module      : vnu_stage_timer
// Description : Loadable down-counter; done is high while the count is zero.
// Revision    : 1.0 - initial release
// ============================================================================
module vnu_stage_timer #(
    parameter int WIDTH = 2
) (
    input  logic             read_clk,
    input  logic             rstn,
    input  logic             clear,
    input  logic             load,
    input  logic [WIDTH-1:0] load_val,
    input  logic             dec,
    output logic             done
);

    logic [WIDTH-1:0] r_count;

    always_ff @(posedge read_clk or negedge rstn) begin
        if (!rstn) begin
            r_count <= '0;
        end else if (clear) begin
            r_count <= '0;
        end else if (load) begin
            r_count <= load_val;
        end else if (dec && (r_count != '0)) begin
            r_count <= r_count - 1'b1;
        end
    end

    assign done = (r_count == '0);

endmodule
`default_nettype wire

// File: rtl/vnu_control_unit.sv
`default_nettype none
// ============================================================================
// Module      : vnu_control_unit
// Description : Layered-decoder VNU control FSM sequencing C2V fetch, VNU
//               pipeline, V2C write-back, layer/iteration bookkeeping.
// Revision    : 1.0 - initial release
// ============================================================================
module vnu_control_unit
    import vnu_control_unit_pkg::*;
#(
    parameter int LAYER_NUM          = VNU_LAYER_NUM_DEF,
    parameter int MAX_ITER           = VNU_MAX_ITER_DEF,
    parameter int MEM_RD_LEVEL       = VNU_MEM_RD_LEVEL_DEF,
    parameter int VNU_PIPELINE_LEVEL = VNU_PIPELINE_LEVEL_DEF,
    parameter int IB_LOAD_CYCLE      = VNU_IB_LOAD_CYCLE_DEF
) (
    input  logic                          read_clk,
    input  logic                          rstn,
    input  logic                          fsm_en,
    input  logic                          c2v_mem_we,
    input  logic                          syndrome_ok,
    output logic                          c2v_rd,
    output logic                          vnu_en,
    output logic                          v2c_mem_we,
    output logic                          layer_finish,
    output logic                          vnu_update_pend,
    output logic                          termination,
    output logic [idx_w(LAYER_NUM)-1:0]   layer_idx,
    output logic [idx_w(MAX_ITER)-1:0]    iter_idx,
    output logic                          c2v_overrun,
    output logic [2:0]                    state
);

    localparam int LAYER_W = idx_w(LAYER_NUM);
    localparam int ITER_W  = idx_w(MAX_ITER);
    localparam int TMR_W   = idx_w(max3(MEM_RD_LEVEL, VNU_PIPELINE_LEVEL, IB_LOAD_CYCLE));

    localparam logic [LAYER_W-1:0] C_LAST_LAYER = LAYER_W'(LAYER_NUM - 1);
    localparam logic [ITER_W-1:0]  C_LAST_ITER  = ITER_W'(MAX_ITER - 1);
    localparam logic [TMR_W-1:0]   C_RD_LOAD    = TMR_W'(MEM_RD_LEVEL - 1);
    localparam logic [TMR_W-1:0]   C_PIPE_LOAD  = TMR_W'(VNU_PIPELINE_LEVEL - 1);
    localparam logic [TMR_W-1:0]   C_IB_LOAD    = TMR_W'(IB_LOAD_CYCLE - 1);

    logic [2:0]         r_state;
    logic [LAYER_W-1:0] r_layer;
    logic [ITER_W-1:0]  r_iter;
    logic               r_overrun;

    logic [2:0]         w_state_nxt;
    logic [LAYER_W-1:0] w_layer_nxt;
    logic [ITER_W-1:0]  w_iter_nxt;
    logic               w_tmr_clear;
    logic               w_tmr_load;
    logic [TMR_W-1:0]   w_tmr_val;
    logic               w_tmr_dec;
    logic               w_tmr_done;

    // One timer serves every multi-cycle stage; it is reloaded on each entry
    vnu_stage_timer #(
        .WIDTH    (TMR_W)
    ) u_stage_timer (
        .read_clk (read_clk),
        .rstn     (rstn),
        .clear    (w_tmr_clear),
        .load     (w_tmr_load),
        .load_val (w_tmr_val),
        .dec      (w_tmr_dec),
        .done     (w_tmr_done)
    );

    always_comb begin
        w_state_nxt = r_state;
        w_layer_nxt = r_layer;
        w_iter_nxt  = r_iter;
        w_tmr_clear = 1'b0;
        w_tmr_load  = 1'b0;
        w_tmr_val   = '0;
        w_tmr_dec   = 1'b0;

        case (r_state)
            VNU_ST_IDLE: begin
                if (c2v_mem_we) begin
                    w_state_nxt = VNU_ST_C2V_FETCH;
                    w_tmr_load  = 1'b1;
                    w_tmr_val   = C_RD_LOAD;
                end
            end
            VNU_ST_C2V_FETCH: begin
                if (w_tmr_done) begin
                    w_state_nxt = VNU_ST_VNU_PIPE;
                    w_tmr_load  = 1'b1;
                    w_tmr_val   = C_PIPE_LOAD;
                end else begin
                    w_tmr_dec   = 1'b1;
                end
            end
            VNU_ST_VNU_PIPE: begin
                if (w_tmr_done) begin
                    w_state_nxt = VNU_ST_V2C_WB;
                end else begin
                    w_tmr_dec   = 1'b1;
                end
            end
            VNU_ST_V2C_WB: begin
                w_state_nxt = VNU_ST_LAYER_END;
            end
            VNU_ST_LAYER_END: begin
                if (r_layer != C_LAST_LAYER) begin
                    w_layer_nxt = r_layer + 1'b1;
                    w_state_nxt = VNU_ST_IDLE;
                end else if (syndrome_ok || (r_iter == C_LAST_ITER)) begin
                    w_state_nxt = VNU_ST_DONE;
                end else begin
                    w_layer_nxt = '0;
                    w_iter_nxt  = r_iter + 1'b1;
                    w_state_nxt = VNU_ST_IB_UPDATE;
                    w_tmr_load  = 1'b1;
                    w_tmr_val   = C_IB_LOAD;
                end
            end
            VNU_ST_IB_UPDATE: begin
                if (w_tmr_done) begin
                    w_state_nxt = VNU_ST_IDLE;
                end else begin
                    w_tmr_dec   = 1'b1;
                end
            end
            VNU_ST_DONE: begin
                w_layer_nxt = '0;
                w_iter_nxt  = '0;
                w_state_nxt = VNU_ST_IDLE;
            end
            default: begin
                w_state_nxt = VNU_ST_IDLE;
            end
        endcase

        // Disable overrides every transition computed above
        if (!fsm_en) begin
            w_state_nxt = VNU_ST_IDLE;
            w_layer_nxt = '0;
            w_iter_nxt  = '0;
            w_tmr_clear = 1'b1;
            w_tmr_load  = 1'b0;
            w_tmr_dec   = 1'b0;
        end
    end

    always_ff @(posedge read_clk or negedge rstn) begin
        if (!rstn) begin
            r_state   <= VNU_ST_IDLE;
            r_layer   <= '0;
            r_iter    <= '0;
            r_overrun <= 1'b0;
        end else begin
            r_state <= w_state_nxt;
            r_layer <= w_layer_nxt;
            r_iter  <= w_iter_nxt;
            if (!fsm_en) begin
                r_overrun <= 1'b0;
            end else if (c2v_mem_we && (r_state != VNU_ST_IDLE)) begin
                r_overrun <= 1'b1;
            end
        end
    end

    assign c2v_rd          = (r_state == VNU_ST_C2V_FETCH);
    assign vnu_en          = (r_state == VNU_ST_VNU_PIPE);
    assign v2c_mem_we      = (r_state == VNU_ST_V2C_WB);
    assign layer_finish    = (r_state == VNU_ST_LAYER_END);
    assign vnu_update_pend = (r_state == VNU_ST_IB_UPDATE);
    assign termination     = (r_state == VNU_ST_DONE);
    assign layer_idx       = r_layer;
    assign iter_idx        = r_iter;
    assign c2v_overrun     = r_overrun;
    assign state           = r_state;

endmodule
`default_nettype wire

// File: tb/tb_vnu_control_unit.sv
`default_nettype none
// ============================================================================
// Module      : tb_vnu_control_unit
// Description : Scoreboard bench for vnu_control_unit with default parameters.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_vnu_control_unit;

    localparam int LN  = 3;
    localparam int MI  = 8;
    localparam int MRL = 2;
    localparam int VPL = 3;
    localparam int IBL = 4;

    localparam logic [2:0] S_IDLE = 3'd0;
    localparam logic [2:0] S_FET  = 3'd1;
    localparam logic [2:0] S_VNU  = 3'd2;
    localparam logic [2:0] S_WB   = 3'd3;
    localparam logic [2:0] S_LE   = 3'd4;
    localparam logic [2:0] S_IB   = 3'd5;
    localparam logic [2:0] S_DONE = 3'd6;

    logic       read_clk = 1'b0;
    logic       rstn = 1'b0;
    logic       fsm_en = 1'b0;
    logic       c2v_mem_we = 1'b0;
    logic       syndrome_ok = 1'b0;
    logic       c2v_rd, vnu_en, v2c_mem_we, layer_finish;
    logic       vnu_update_pend, termination, c2v_overrun;
    logic [1:0] layer_idx;
    logic [2:0] iter_idx;
    logic [2:0] state;

    int n_chk = 0;
    int n_err = 0;
    int cur_layer = 0;
    int cur_iter = 0;
    logic cur_ovr = 1'b0;

    logic [15:0] exp_q[$];
    string       tag_q[$];

    always #5 read_clk = ~read_clk;

    vnu_control_unit #(
        .LAYER_NUM          (LN),
        .MAX_ITER           (MI),
        .MEM_RD_LEVEL       (MRL),
        .VNU_PIPELINE_LEVEL (VPL),
        .IB_LOAD_CYCLE      (IBL)
    ) dut (
        .read_clk        (read_clk),
        .rstn            (rstn),
        .fsm_en          (fsm_en),
        .c2v_mem_we      (c2v_mem_we),
        .syndrome_ok     (syndrome_ok),
        .c2v_rd          (c2v_rd),
        .vnu_en          (vnu_en),
        .v2c_mem_we      (v2c_mem_we),
        .layer_finish    (layer_finish),
        .vnu_update_pend (vnu_update_pend),
        .termination     (termination),
        .layer_idx       (layer_idx),
        .iter_idx        (iter_idx),
        .c2v_overrun     (c2v_overrun),
        .state           (state)
    );

    // {0, state, rd, vnu, wb, lf, pend, term, layer[1:0], iter[2:0], ovr}
    function automatic logic [15:0] mk(input logic [2:0] st, input int lay, input int it, input logic ov);
        logic [5:0] sb;
        logic [1:0] l2;
        logic [2:0] i3;
        case (st)
            S_FET:   sb = 6'b100000;
            S_VNU:   sb = 6'b010000;
            S_WB:    sb = 6'b001000;
            S_LE:    sb = 6'b000100;
            S_IB:    sb = 6'b000010;
            S_DONE:  sb = 6'b000001;
            default: sb = 6'b000000;
        endcase
        l2 = lay[1:0];
        i3 = it[2:0];
        return {1'b0, st, sb, l2, i3, ov};
    endfunction

    function automatic logic [15:0] obs();
        return {1'b0, state, c2v_rd, vnu_en, v2c_mem_we, layer_finish,
                vnu_update_pend, termination, layer_idx, iter_idx, c2v_overrun};
    endfunction

    task automatic check(input string tag, input logic [15:0] got, input logic [15:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h at %0t", tag, got, exp, $time);
        end
    endtask

    task automatic push(input string tag, input logic [15:0] v);
        exp_q.push_back(v);
        tag_q.push_back(tag);
    endtask

    task automatic step();
        @(posedge read_clk);
        #1;
        if (exp_q.size() > 0) check(tag_q.pop_front(), obs(), exp_q.pop_front());
    endtask

    task automatic drain();
        int n;
        n = 0;
        while (exp_q.size() > 0 && n < 60) begin
            step();
            n++;
        end
        check("sb_empty", 16'(exp_q.size()), 16'h0);
        exp_q.delete();
        tag_q.delete();
    endtask

    // One layer from the c2v_mem_we pulse onward. inj: entry after which an
    // extra c2v_mem_we is driven; abort_at: entry after which rstn is pulsed.
    task automatic run_layer(input logic syn, input int inj, input int abort_at);
        logic [2:0] st;
        logic       ov;
        syndrome_ok = syn;
        for (int j = 0; j < MRL + VPL + 2; j++) begin
            if (j < MRL)            st = S_FET;
            else if (j < MRL + VPL) st = S_VNU;
            else if (j == MRL + VPL) st = S_WB;
            else                    st = S_LE;
            ov = cur_ovr | ((inj >= 0) && (j > inj));
            push("stage", mk(st, cur_layer, cur_iter, ov));
        end
        if (inj >= 0) cur_ovr = 1'b1;
        if (cur_layer < LN - 1) begin
            cur_layer++;
            push("next_layer", mk(S_IDLE, cur_layer, cur_iter, cur_ovr));
        end else if (syn || cur_iter == MI - 1) begin
            push("done", mk(S_DONE, cur_layer, cur_iter, cur_ovr));
            cur_layer = 0;
            cur_iter = 0;
            push("after_done", mk(S_IDLE, 0, 0, cur_ovr));
        end else begin
            cur_layer = 0;
            cur_iter++;
            for (int k = 0; k < IBL; k++) push("ib_update", mk(S_IB, 0, cur_iter, cur_ovr));
            push("after_ib", mk(S_IDLE, 0, cur_iter, cur_ovr));
        end

        c2v_mem_we = 1'b1;
        step();
        c2v_mem_we = 1'b0;
        for (int j = 0; j < MRL + VPL + 1; j++) begin
            if (j == abort_at) begin
                rstn = 1'b0;
                #1;
                check("rst_async", obs(), 16'h0);
                exp_q.delete();
                tag_q.delete();
                @(posedge read_clk);
                #1;
                rstn = 1'b1;
                cur_layer = 0;
                cur_iter = 0;
                cur_ovr = 1'b0;
                syndrome_ok = 1'b0;
                return;
            end
            if (j == inj) c2v_mem_we = 1'b1;
            step();
            c2v_mem_we = 1'b0;
        end
        drain();
        syndrome_ok = 1'b0;
    endtask

    initial begin
        fsm_en = 1'b1;
        repeat (2) @(posedge read_clk);
        #1;
        check("reset_hold", obs(), 16'h0);
        rstn = 1'b1;

        for (int k = 0; k < 3; k++) begin
            push("idle_hold", mk(S_IDLE, 0, 0, 1'b0));
            step();
        end

        // three layers without convergence, then IB reload
        for (int k = 0; k < LN; k++) run_layer(1'b0, -1, -1);

        // early termination on the last layer of the second iteration
        run_layer(1'b0, -1, -1);
        run_layer(1'b0, -1, -1);
        run_layer(1'b1, -1, -1);

        // full MAX_ITER frame with no convergence
        for (int k = 0; k < LN * MI; k++) run_layer(1'b0, -1, -1);

        // overrun during VNU_PIPE, timing unchanged
        run_layer(1'b0, MRL, -1);

        // fsm_en low clears flag and indices and ignores c2v_mem_we
        fsm_en = 1'b0;
        c2v_mem_we = 1'b1;
        cur_layer = 0;
        cur_iter = 0;
        cur_ovr = 1'b0;
        push("en_low", mk(S_IDLE, 0, 0, 1'b0));
        step();
        push("en_low_we", mk(S_IDLE, 0, 0, 1'b0));
        step();
        c2v_mem_we = 1'b0;
        fsm_en = 1'b1;
        push("en_back", mk(S_IDLE, 0, 0, 1'b0));
        step();

        // advance to layer 1, then abort with reset during VNU_PIPE
        run_layer(1'b0, -1, -1);
        run_layer(1'b0, -1, MRL);
        push("post_reset_idle", mk(S_IDLE, 0, 0, 1'b0));
        step();
        run_layer(1'b0, -1, -1);

        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog expired");
    end

endmodule
`default_nettype wire

// File: doc/vnu_control_unit.md
VNU_CONTROL_UNIT -- requirements
Module: vnu_control_unit

Interface
REQ-001 Parameter LAYER_NUM, default 3: layers per decoding iteration.
REQ-002 Parameter MAX_ITER, default 8: maximum iterations per frame.
REQ-003 Parameter MEM_RD_LEVEL, default 2: C2V memory read latency in cycles.
REQ-004 Parameter VNU_PIPELINE_LEVEL, default 3: VNU datapath latency in cycles.
REQ-005 Parameter IB_LOAD_CYCLE, default 4: cycles to reload VNU IB-RAMs between iterations.
REQ-006 read_clk  in  1  clock; all logic on the rising edge.
REQ-007 rstn  in  1  reset, asynchronous, active-low.
REQ-008 fsm_en  in  1  enable; low forces a synchronous return to IDLE.
REQ-009 c2v_mem_we  in  1  pulse from the CNU controller: the C2V page of the current layer is written.
REQ-010 syndrome_ok  in  1  all parity checks satisfied; sampled only in LAYER_END.
REQ-011 c2v_rd  out  1  C2V memory read enable.
REQ-012 vnu_en  out  1  VNU datapath enable.
REQ-013 v2c_mem_we  out  1  V2C memory write enable.
REQ-014 layer_finish  out  1  one-cycle pulse at the end of each layer.
REQ-015 vnu_update_pend  out  1  high while the IB-RAMs reload.
REQ-016 termination  out  1  one-cycle pulse when the frame ends.
REQ-017 layer_idx  out  clog2(LAYER_NUM)  current layer, binary.
REQ-018 iter_idx  out  clog2(MAX_ITER)  current iteration, binary.
REQ-019 c2v_overrun  out  1  sticky error flag.
REQ-020 state  out  3  FSM state encoding.

Function
REQ-021 States and encodings SHALL be: IDLE=0, C2V_FETCH=1, VNU_PIPE=2, V2C_WB=3, LAYER_END=4, IB_UPDATE=5, DONE=6.
REQ-022 IDLE SHALL move to C2V_FETCH on the cycle after c2v_mem_we=1; otherwise it holds.
REQ-023 C2V_FETCH SHALL hold for exactly MEM_RD_LEVEL cycles with c2v_rd=1, then move to VNU_PIPE.
REQ-024 VNU_PIPE SHALL hold for exactly VNU_PIPELINE_LEVEL cycles with vnu_en=1, then move to V2C_WB.
REQ-025 V2C_WB SHALL last 1 cycle with v2c_mem_we=1, then move to LAYER_END.
REQ-026 LAYER_END SHALL last 1 cycle with layer_finish=1.
REQ-027 LAYER_END when layer_idx<LAYER_NUM-1: increment layer_idx, next state IDLE.
REQ-028 LAYER_END when layer_idx=LAYER_NUM-1, and either syndrome_ok=1 or iter_idx=MAX_ITER-1: next state DONE.
REQ-029 LAYER_END when layer_idx=LAYER_NUM-1 otherwise: layer_idx wraps to 0, iter_idx increments, next state IB_UPDATE.
REQ-030 IB_UPDATE SHALL hold exactly IB_LOAD_CYCLE cycles with vnu_update_pend=1, then move to IDLE.
REQ-031 DONE SHALL last 1 cycle with termination=1, clear layer_idx and iter_idx to 0, then move to IDLE.
REQ-032 Stage counters SHALL be down-counters loaded on state entry; there SHALL be no extra terminal cycle.
REQ-033 c2v_mem_we=1 in any state other than IDLE SHALL be ignored and SHALL set c2v_overrun, which stays set until reset or fsm_en=0.
REQ-034 fsm_en=0 SHALL take priority over all transitions: next state IDLE, counters and c2v_overrun cleared, all strobes 0.
REQ-035 All outputs SHALL be decoded from registered state and counters only, with no input-to-output combinational path.

Reset
REQ-036 rstn=0 SHALL immediately set state=IDLE, layer_idx=0, iter_idx=0, c2v_overrun=0, and all strobes (c2v_rd, vnu_en, v2c_mem_we, layer_finish, vnu_update_pend, termination) to 0.
REQ-037 Reset asserted mid-operation SHALL abort the frame; after release, operation waits in IDLE for c2v_mem_we.

Structure
REQ-038 State encodings and the default latency constants SHALL live in the shared decoder definitions package, next to the CNU controller constants.
REQ-039 One sub-module, vnu_stage_timer (loadable down-counter with a terminal flag), SHALL be instantiated once and shared by C2V_FETCH, VNU_PIPE and IB_UPDATE.

Verification
REQ-040 One c2v_mem_we pulse at cycle 10, defaults -> c2v_rd at cycles 11-12, vnu_en at 13-15, v2c_mem_we at 16, layer_finish at 17.
REQ-041 Three layers with syndrome_ok=0 -> layer_idx 0,1,2,0; iter_idx 0->1; vnu_update_pend high 4 cycles after the third layer_finish.
REQ-042 syndrome_ok=1 at the third LAYER_END -> termination one cycle later; layer_idx=0 and iter_idx=0 afterwards.
REQ-043 syndrome_ok held 0 for 24 layers -> termination after the 24th layer_finish, with no IB_UPDATE entered in that final iteration.
REQ-044 c2v_mem_we asserted during VNU_PIPE -> c2v_overrun=1, sequence timing unchanged; fsm_en=0 then clears the flag.
REQ-045 rstn pulsed low during VNU_PIPE -> all outputs 0 at once; the next c2v_mem_we restarts from layer 0.
